// File: rtl/pulp_clock_gate_ctrl.sv
// Sequencer for an async-enable clock gate: collects requests, handshakes
// the gate enable, grants the clock, and gates it off after an idle period.
module pulp_clock_gate_ctrl #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDLE_W  = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    input  logic               force_on_i,
    input  logic [IDLE_W-1:0]  idle_cycles_i,
    output logic               en_o,
    input  logic               en_ack_i,
    output logic               active_o,
    output logic               err_o
);

    typedef enum logic [1:0] {
        S_OFF,
        S_WAKE,
        S_ON,
        S_SLEEP
    } state_e;

    state_e              r_state;
    state_e              w_next;
    logic [IDLE_W-1:0]   r_cnt;
    logic [IDLE_W-1:0]   w_cnt_next;
    logic                r_err;
    logic                w_any_req;

    assign w_any_req = (|req_i) | force_on_i;

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        unique case (r_state)
            S_OFF: begin
                if (w_any_req) w_next = S_WAKE;
            end
            S_WAKE: begin
                if (en_ack_i) begin
                    w_next     = S_ON;
                    w_cnt_next = idle_cycles_i;
                end
            end
            S_ON: begin
                if (w_any_req) begin
                    w_cnt_next = idle_cycles_i;
                end else if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - IDLE_W'(1);
                end else begin
                    w_next = S_SLEEP;
                end
            end
            S_SLEEP: begin
                // Must see the gate fully off before a new wake-up
                if (!en_ack_i) w_next = S_OFF;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_OFF;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (r_state == S_ON && !en_ack_i) r_err <= 1'b1;
        end
    end

    // Decoded straight from the state register so en_o cannot glitch
    assign en_o     = (r_state == S_WAKE) || (r_state == S_ON);
    assign active_o = (r_state == S_ON);
    assign gnt_o    = req_i & {NUM_REQ{r_state == S_ON}};
    assign err_o    = r_err;

endmodule

// File: tb/tb_pulp_clock_gate_ctrl.sv
// Directed bench for pulp_clock_gate_ctrl; gate ack modelled as en_o
// delayed two cycles with an optional override.
module tb_pulp_clock_gate_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [3:0] req_i;
    logic [3:0] gnt_o;
    logic       force_on_i;
    logic [7:0] idle_cycles_i;
    logic       en_o;
    logic       en_ack_i;
    logic       active_o;
    logic       err_o;

    logic [1:0] ack_pipe = 2'b00;
    logic       ack_ovr  = 1'b0;
    int         n_chk = 0;
    int         n_err = 0;

    pulp_clock_gate_ctrl #(.NUM_REQ(4), .IDLE_W(8)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_i        (req_i),
        .gnt_o        (gnt_o),
        .force_on_i   (force_on_i),
        .idle_cycles_i(idle_cycles_i),
        .en_o         (en_o),
        .en_ack_i     (en_ack_i),
        .active_o     (active_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) ack_pipe <= {ack_pipe[0], en_o};
    assign en_ack_i = ack_ovr ? 1'b0 : ack_pipe[1];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_i         = 1'b1;
        req_i         = 4'b0000;
        force_on_i    = 1'b0;
        idle_cycles_i = 8'd3;
        tick();
        tick();
        settle();
        chk("rst_en", en_o, 0);
        chk("rst_gnt", gnt_o, 0);
        chk("rst_act", active_o, 0);
        chk("rst_err", err_o, 0);
        rst_i = 1'b0;

        // cycle 0: first request
        tick(); req_i = 4'b0001; settle();
        chk("c0_en", en_o, 0);
        tick(); settle();
        chk("c1_en", en_o, 1);
        chk("c1_act", active_o, 0);
        tick(); settle();
        tick(); settle();
        chk("c3_gnt", gnt_o, 0);
        chk("c3_act", active_o, 0);
        tick(); settle();
        chk("c4_gnt", gnt_o, 4'b0001);
        chk("c4_act", active_o, 1);
        for (int i = 5; i <= 9; i++) tick();

        // cycle 10: release, idle 3
        tick(); req_i = 4'b0000; settle();
        chk("c10_gnt", gnt_o, 0);
        chk("c10_en", en_o, 1);
        for (int i = 11; i <= 13; i++) begin
            tick(); settle();
            chk("idle_en", en_o, 1);
        end
        tick(); settle();
        chk("c14_en", en_o, 0);
        chk("c14_act", active_o, 0);

        // cycle 15: request during SLEEP must wait
        tick(); req_i = 4'b0100; settle();
        chk("c15_gnt", gnt_o, 0);
        chk("c15_en", en_o, 0);
        tick(); settle();
        chk("c16_en", en_o, 0);
        tick(); settle();
        chk("c17_off_en", en_o, 0);
        tick(); settle();
        chk("c18_wake_en", en_o, 1);
        tick(); settle();
        tick(); settle();
        chk("c20_gnt", gnt_o, 0);
        tick(); settle();
        chk("c21_gnt", gnt_o, 4'b0100);

        // cycle 22: two requesters, then one drops
        tick(); req_i = 4'b1010; settle();
        chk("c22_gnt", gnt_o, 4'b1010);
        tick(); tick();
        tick(); req_i = 4'b1000; settle();
        chk("c25_gnt", gnt_o, 4'b1000);
        for (int i = 26; i <= 30; i++) begin
            tick(); settle();
            chk("hold_en", en_o, 1);
        end
        chk("c30_act", active_o, 1);
        tick(); req_i = 4'b0000; settle();
        chk("c31_en", en_o, 1);
        tick(); tick(); tick(); settle();
        chk("c34_en", en_o, 1);
        tick(); settle();
        chk("c35_en", en_o, 0);
        tick(); tick();

        // cycle 38: force_on with zero idle
        tick(); idle_cycles_i = 8'd0; force_on_i = 1'b1; settle();
        chk("c38_en", en_o, 0);
        tick(); settle();
        chk("c39_en", en_o, 1);
        tick(); tick(); settle();
        chk("c41_act", active_o, 0);
        tick(); settle();
        chk("c42_act", active_o, 1);
        chk("c42_gnt", gnt_o, 0);
        for (int i = 43; i <= 47; i++) begin
            tick(); settle();
            chk("force_act", active_o, 1);
        end
        tick(); force_on_i = 1'b0; settle();
        chk("c48_act", active_o, 1);
        tick(); settle();
        chk("c49_act", active_o, 0);
        chk("c49_en", en_o, 0);
        tick(); tick();

        // cycle 52: wake again, then ack error and reset
        tick(); idle_cycles_i = 8'd3; req_i = 4'b0001; settle();
        chk("c52_en", en_o, 0);
        tick(); tick(); tick(); tick(); settle();
        chk("c56_gnt", gnt_o, 4'b0001);
        chk("c56_err", err_o, 0);
        tick(); ack_ovr = 1'b1; settle();
        chk("c57_err", err_o, 0);
        tick(); ack_ovr = 1'b0; settle();
        chk("c58_err", err_o, 1);
        chk("c58_act", active_o, 1);
        tick(); settle();
        chk("c59_err", err_o, 1);
        tick(); rst_i = 1'b1; settle();
        tick(); rst_i = 1'b0; settle();
        chk("c61_en", en_o, 0);
        chk("c61_gnt", gnt_o, 0);
        chk("c61_act", active_o, 0);
        chk("c61_err", err_o, 0);
        tick(); settle();
        chk("c62_en", en_o, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
